// File: rtl/i2s_rx_master.sv
// I2S receive master for the Pmod I2S2 ADC: generates MCLK/SCLK/LRCK from clk
// and deserialises 24-bit stereo samples into a parallel pair with a strobe.
module i2s_rx_master #(
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned MCLK_HALF    = 1,
  parameter int unsigned SLOTS_PER_CH = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mclk_out,
  output logic              sclk_out,
  output logic              lrck_out,
  input  logic              sdin_in,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              new_packet
);

  localparam int unsigned SCLK_HALF = 4 * MCLK_HALF;
  localparam int unsigned PH_N      = 2 * SCLK_HALF;
  localparam int unsigned PH_W      = $clog2(PH_N);
  localparam int unsigned SLOT_N    = 2 * SLOTS_PER_CH;
  localparam int unsigned SLOT_W    = $clog2(SLOT_N);
  localparam int unsigned MC_W      = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  logic [PH_W-1:0]   ph_q, ph_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic              mclk_d, sclk_d, lrck_d;
  logic              cap, left_win, right_win, last_bit, left_clr, right_clr;
  logic [DATA_W-1:0] left_sr, right_sr;

  // Slot/phase counters and next values of the generated clocks
  always_comb begin
    ph_d     = ph_q + PH_W'(1);
    slot_d   = slot_q;
    mc_cnt_d = mc_cnt_q + MC_W'(1);
    mclk_d   = mclk_out;
    if (ph_q == PH_W'(PH_N - 1)) begin
      ph_d   = '0;
      slot_d = (slot_q == SLOT_W'(SLOT_N - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
    if (mc_cnt_q == MC_W'(MCLK_HALF - 1)) begin
      mc_cnt_d = '0;
      mclk_d   = ~mclk_out;
    end
    sclk_d = (ph_d >= PH_W'(SCLK_HALF));
    lrck_d = (slot_d >= SLOT_W'(SLOTS_PER_CH));
  end

  // Capture decode; data sits one slot after the LRCK transition
  always_comb begin
    cap       = (ph_q == PH_W'(SCLK_HALF));
    left_win  = (slot_q >= SLOT_W'(1)) && (slot_q <= SLOT_W'(DATA_W));
    right_win = (slot_q >= SLOT_W'(SLOTS_PER_CH + 1)) &&
                (slot_q <= SLOT_W'(SLOTS_PER_CH + DATA_W));
    last_bit  = (slot_q == SLOT_W'(SLOTS_PER_CH + DATA_W));
    left_clr  = (slot_q == '0) && (ph_q == '0);
    right_clr = (slot_q == SLOT_W'(SLOTS_PER_CH)) && (ph_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q     <= '0;
      slot_q   <= '0;
      mc_cnt_q <= '0;
      mclk_out <= 1'b0;
      sclk_out <= 1'b0;
      lrck_out <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      slot_q   <= slot_d;
      mc_cnt_q <= mc_cnt_d;
      mclk_out <= mclk_d;
      sclk_out <= sclk_d;
      lrck_out <= lrck_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      left_sr    <= '0;
      right_sr   <= '0;
      left_data  <= '0;
      right_data <= '0;
      new_packet <= 1'b0;
    end else begin
      if (left_clr) begin
        left_sr <= '0;
      end else if (cap && left_win) begin
        left_sr <= {left_sr[DATA_W-2:0], sdin_in};
      end
      if (right_clr) begin
        right_sr <= '0;
      end else if (cap && right_win) begin
        right_sr <= {right_sr[DATA_W-2:0], sdin_in};
      end
      // Both channels publish together on the right-LSB capture
      if (cap && last_bit) begin
        left_data  <= left_sr;
        right_data <= {right_sr[DATA_W-2:0], sdin_in};
      end
      new_packet <= cap && last_bit;
    end
  end

endmodule

// File: doc/i2s_rx_master.md
Name: i2s_rx_master

Overview:
- Upstream capture stage for the dual-channel FIR engine on Basys-3.
- Acts as I2S bus master for the Pmod I2S2 ADC: generates MCLK, LRCK and SCLK from the system clock.
- Deserialises the 24-bit left/right samples on SDIN and presents them as a parallel stereo pair with a one-cycle new_packet strobe.
- left_data feeds FIR input channel 0, right_data feeds channel 1, new_packet drives the FIR engine's new_packet.

Parameters:
DATA_W, 24, sample width per channel (MSB-first, two's complement, passed through unmodified)
MCLK_HALF, 1, MCLK half-period in clk cycles; SCLK half-period SCLK_HALF = 4*MCLK_HALF (localparam)
SLOTS_PER_CH, 32, SCLK periods per channel; frame = 2*SLOTS_PER_CH slots (MCLK = 256*fs at defaults)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
mclk_out  output  1  ADC master clock, toggles every MCLK_HALF clk cycles
sclk_out  output  1  I2S bit clock, period 2*SCLK_HALF clk cycles
lrck_out  output  1  I2S word select: 0 = left, 1 = right
sdin_in  input  1  serial data from ADC
left_data  output  DATA_W  last complete left sample
right_data  output  DATA_W  last complete right sample
new_packet  output  1  one-cycle strobe: left_data/right_data just updated

Behaviour:
- Reset (rst high at a clk edge): mclk_out, sclk_out, lrck_out, new_packet = 0; left_data, right_data = 0; divider, slot counter and shift registers = 0. A partial frame is discarded with no new_packet. Reset mid-frame behaves identically.
- Cycle 0 is the first clk cycle after rst deasserts. Slot k occupies cycles k*2*SCLK_HALF .. (k+1)*2*SCLK_HALF-1, with k = 0..63 (defaults) and wrap to 0.
- Divider phase p = 0..2*SCLK_HALF-1 within a slot:
  - sclk_out = 0 for p < SCLK_HALF and 1 otherwise (falls at slot start, rises at mid-slot).
  - mclk_out toggles every MCLK_HALF cycles and is 0 at p = 0.
- lrck_out changes only at slot start (sclk falling): 0 for slots 0..SLOTS_PER_CH-1, 1 for the remaining slots.
- Capture: sdin_in is sampled at the clk edge where sclk_out goes 0→1 (p = SCLK_HALF).
  - I2S one-bit delay: left MSB..LSB in slots 1..DATA_W; right MSB..LSB in slots SLOTS_PER_CH+1..SLOTS_PER_CH+DATA_W.
  - Other slots are ignored (zero padding or trailing bits).
- Shift registers shift left, inserting sdin at the LSB; they clear at the start of their channel's slot 0.
- Update: on the right-LSB capture edge, left_data <= left shift register and right_data <= completed right word, registered together. new_packet is high for exactly the following cycle.
  - Defaults: pulse in cycle 452 → visible 453, then every 512 cycles.
- Outputs hold between updates; the two channels always update in the same cycle (never torn).
- sdin_in is treated as synchronous to the generated clocks; no synchroniser, no other handshake. The consumer must accept the data within the new_packet cycle or latch it.
- new_packet never asserts twice in one frame, and never before the first complete frame after reset.

Test Plan:
- Reset hold: rst high 20 cycles with sdin toggling → all outputs 0, no new_packet; after release, sclk_out rises at cycle 4, lrck_out rises at cycle 256.
- Stereo capture: ADC model drives left = 24'h100000, right = 24'hF0000F → new_packet single pulse at cycle 453; left_data = 24'h100000, right_data = 24'hF0000F.
- Padding/delay: same frame, but sdin = 1 in slots 0, 25..32, 57..63 → captured values unchanged (24'h100000 / 24'hF0000F).
- Back-to-back frames: frame 2 = 24'h7FFFFF / 24'h800000 → pulse at 965 with new values; values from frame 1 held through cycles 454..964.
- Reset mid-frame: rst asserted at cycle 300 for 1 cycle → no pulse at 453; outputs 0; next pulse 453 cycles after the rst release.
- Clock ratios: MCLK_HALF = 2 → sclk period 16, frame 1024, mclk_out period 4, pulse at cycle 905.
